// File: rtl/bus_rf_pkg.sv
// Shared constants, response type and strobe helper for the mini-processor bus register file.
package bus_rf_pkg;

  localparam int unsigned BUS_ADDR_W = 16;
  localparam logic [BUS_ADDR_W-1:0] RF_BASE_ADDR = 16'h0110;
  localparam int unsigned RF_DEPTH = 10;
  localparam int unsigned RF_WIDTH = 64;

  // Widest register the strobe helper supports: 64 lanes of 8 bits.
  localparam int unsigned MAX_STRB  = 64;
  localparam int unsigned MAX_WIDTH = MAX_STRB * 8;

  typedef struct packed {
    logic ack;
    logic err;
  } bus_rsp_t;

  function automatic logic [MAX_WIDTH-1:0] byte_mask(input logic [MAX_STRB-1:0] strb);
    logic [MAX_WIDTH-1:0] mask;
    for (int k = 0; k < MAX_STRB; k++) begin
      mask[8*k +: 8] = {8{strb[k]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/rf_word.sv
// One register of the bus register file: async reset, sync clear, byte-masked write.
module rf_word
  import bus_rf_pkg::*;
#(
  parameter int unsigned WIDTH = RF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             we,
  input  logic [WIDTH-1:0] mask,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] q
);

  // NOTE: every word is reset (not left as uninitialised RAM) because reg_q
  // exposes all of them live to the core; state uses non-blocking assignments
  // so all words and the response register update from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (we) begin
      q <= (q & ~mask) | (wdata & mask);
    end
  end

endmodule

// File: rtl/bus_register_file.sv
// Parametrised register file slave: address decode, error logic, 1-cycle response pipeline, read mux.
module bus_register_file
  import bus_rf_pkg::*;
#(
  parameter int unsigned       DEPTH     = RF_DEPTH,
  parameter int unsigned       WIDTH     = RF_WIDTH,
  parameter int unsigned       ADDR_W    = BUS_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(RF_BASE_ADDR),
  parameter logic [DEPTH-1:0]  RO_MASK   = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req,
  input  logic                   wr,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic [WIDTH/8-1:0]     wstrb,
  input  logic                   clear,
  output logic                   ack,
  output logic                   err,
  output logic [WIDTH-1:0]       rdata,
  output logic [DEPTH*WIDTH-1:0] reg_q
);

  // One extra bit so BASE_ADDR+DEPTH cannot wrap at the top of the address space.
  localparam logic [ADDR_W:0] BASE_X = {1'b0, BASE_ADDR};

  logic [ADDR_W:0]    addr_x;
  logic [DEPTH-1:0]   sel;
  logic               hit;
  logic               ro_hit;
  logic [WIDTH-1:0]   wmask;
  logic [DEPTH-1:0]   we;
  bus_rsp_t           rsp_d, rsp_q;
  logic [DEPTH-1:0]   rd_sel_d, rd_sel_q;
  logic [WIDTH-1:0]   word_q [DEPTH];

  assign addr_x = {1'b0, addr};
  assign wmask  = WIDTH'(byte_mask(MAX_STRB'(wstrb)));

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = (addr_x == BASE_X + (ADDR_W+1)'(i));
    end
  end

  assign hit    = |sel;
  assign ro_hit = |(sel & RO_MASK);

  assign we       = (req && wr) ? (sel & ~RO_MASK) : '0;
  assign rd_sel_d = (req && !wr) ? sel : '0;

  always_comb begin
    rsp_d.ack = req;
    rsp_d.err = req && (!hit || (wr && ro_hit));
  end

  // The read select is registered, not the data, so rdata reflects any
  // clear or write applied at the same edge that sampled the read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_q    <= '0;
      rd_sel_q <= '0;
    end else begin
      rsp_q    <= rsp_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    rf_word #(
      .WIDTH (WIDTH)
    ) u_word (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .we    (we[i]),
      .mask  (wmask),
      .wdata (wdata),
      .q     (word_q[i])
    );
    assign reg_q[i*WIDTH +: WIDTH] = word_q[i];
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdata = rdata | (word_q[i] & {WIDTH{rd_sel_q[i]}});
    end
  end

  assign ack = rsp_q.ack;
  assign err = rsp_q.err;

endmodule

// File: tb/tb_bus_register_file.sv
// Directed self-checking bench for bus_register_file (10 x 64-bit, base 0x0110, register 0 read-only).
module tb_bus_register_file;

  localparam int DEPTH = 10;
  localparam int WIDTH = 64;
  localparam int FLAT  = DEPTH * WIDTH;

  logic            clk = 1'b0;
  logic            reset;
  logic            req;
  logic            wr;
  logic [15:0]     addr;
  logic [63:0]     wdata;
  logic [7:0]      wstrb;
  logic            clear;
  logic            ack;
  logic            err;
  logic [63:0]     rdata;
  logic [FLAT-1:0] reg_q;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_regs [DEPTH];

  bus_register_file #(
    .DEPTH     (10),
    .WIDTH     (64),
    .ADDR_W    (16),
    .BASE_ADDR (16'h0110),
    .RO_MASK   (10'b00_0000_0001)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .wstrb (wstrb),
    .clear (clear),
    .ack   (ack),
    .err   (err),
    .rdata (rdata),
    .reg_q (reg_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [FLAT-1:0] obs, input logic [FLAT-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FLAT-1:0] exp_flat();
    logic [FLAT-1:0] f;
    for (int i = 0; i < DEPTH; i++) f[i*WIDTH +: WIDTH] = exp_regs[i];
    return f;
  endfunction

  task automatic check_regs(input string tag);
    check(tag, reg_q, exp_flat());
  endtask

  task automatic check_resp(input string tag, input logic exp_err, input logic [WIDTH-1:0] exp_rdata);
    check({tag, ".ack"},   FLAT'(ack),   FLAT'(1'b1));
    check({tag, ".err"},   FLAT'(err),   FLAT'(exp_err));
    check({tag, ".rdata"}, FLAT'(rdata), FLAT'(exp_rdata));
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".ack"}, FLAT'(ack), FLAT'(1'b0));
  endtask

  task automatic drive(input logic r, input logic w, input logic [15:0] a,
                       input logic [63:0] d, input logic [7:0] s, input logic c);
    req   = r;
    wr    = w;
    addr  = a;
    wdata = d;
    wstrb = s;
    clear = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) exp_regs[i] = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 64'h0, 8'h00, 1'b0);
    zero_model();

    // Reset state, before any clock edge
    #2;
    check("rst.ack",   FLAT'(ack),   FLAT'(1'b0));
    check("rst.err",   FLAT'(err),   FLAT'(1'b0));
    check("rst.rdata", FLAT'(rdata), FLAT'(64'h0));
    check_regs("rst.regs");
    tick();
    reset = 1'b0;
    tick();
    check_idle("idle");

    // Full write, then read-after-write of the same register
    drive(1'b1, 1'b1, 16'h0113, 64'hDEAD_BEEF_0123_4567, 8'hFF, 1'b0);
    tick();
    exp_regs[3] = 64'hDEAD_BEEF_0123_4567;
    check_resp("wr113", 1'b0, 64'h0);
    check_regs("wr113.regs");
    drive(1'b1, 1'b0, 16'h0113, 64'h0, 8'h00, 1'b0);
    tick();
    check_resp("rd113", 1'b0, 64'hDEAD_BEEF_0123_4567);
    check("rd113.slice", FLAT'(reg_q[3*64 +: 64]), FLAT'(64'hDEAD_BEEF_0123_4567));
    drive(1'b0, 1'b0, 16'h0000, 64'h0, 8'h00, 1'b0);
    tick();
    check_idle("rd113.after");

    // Byte strobes on 0x0115
    drive(1'b1, 1'b1, 16'h0115, 64'h1111_1111_1111_1111, 8'hFF, 1'b0);
    tick();
    exp_regs[5] = 64'h1111_1111_1111_1111;
    check_resp("wr115.full", 1'b0, 64'h0);
    drive(1'b1, 1'b1, 16'h0115, 64'hFFFF_FFFF_FFFF_FFFF, 8'b0000_0101, 1'b0);
    tick();
    exp_regs[5] = 64'h1111_1111_11FF_11FF;
    check_resp("wr115.strb", 1'b0, 64'h0);
    drive(1'b1, 1'b0, 16'h0115, 64'h0, 8'h00, 1'b0);
    tick();
    check_resp("rd115", 1'b0, 64'h1111_1111_11FF_11FF);
    drive(1'b1, 1'b1, 16'h0115, 64'h0, 8'h00, 1'b0);
    tick();
    check_resp("wr115.nostrb", 1'b0, 64'h0);
    check_regs("wr115.nostrb.regs");

    // Out-of-range on both sides of the window
    drive(1'b1, 1'b0, 16'h011A, 64'h0, 8'h00, 1'b0);
    tick();
    check_resp("rd11A", 1'b1, 64'h0);
    drive(1'b1, 1'b0, 16'h010F, 64'h0, 8'h00, 1'b0);
    tick();
    check_resp("rd10F", 1'b1, 64'h0);
    drive(1'b1, 1'b1, 16'h011A, 64'h1234_5678_9ABC_DEF0, 8'hFF, 1'b0);
    tick();
    check_resp("wr11A", 1'b1, 64'h0);
    check_regs("oor.regs");

    // Last in-range register
    drive(1'b1, 1'b1, 16'h0119, 64'h0000_0000_0000_0099, 8'hFF, 1'b0);
    tick();
    exp_regs[9] = 64'h0000_0000_0000_0099;
    check_resp("wr119", 1'b0, 64'h0);
    drive(1'b1, 1'b0, 16'h0119, 64'h0, 8'h00, 1'b0);
    tick();
    check_resp("rd119", 1'b0, 64'h0000_0000_0000_0099);

    // Read-only register 0
    drive(1'b1, 1'b1, 16'h0110, 64'h5, 8'hFF, 1'b0);
    tick();
    check_resp("wr110.ro", 1'b1, 64'h0);
    check_regs("wr110.ro.regs");
    drive(1'b1, 1'b0, 16'h0110, 64'h0, 8'h00, 1'b0);
    tick();
    check_resp("rd110", 1'b0, 64'h0);

    // Clear beats a simultaneous write
    drive(1'b1, 1'b1, 16'h0111, 64'hA, 8'hFF, 1'b0);
    tick();
    exp_regs[1] = 64'hA;
    check_resp("wr111", 1'b0, 64'h0);
    check_regs("wr111.regs");
    drive(1'b1, 1'b1, 16'h0111, 64'hB, 8'hFF, 1'b1);
    tick();
    zero_model();
    check_resp("wr111.clr", 1'b0, 64'h0);
    check_regs("clr.regs");
    drive(1'b1, 1'b0, 16'h0111, 64'h0, 8'h00, 1'b0);
    tick();
    check_resp("rd111", 1'b0, 64'h0);

    // Read in the same cycle as clear returns zero
    drive(1'b1, 1'b1, 16'h0112, 64'h7, 8'hFF, 1'b0);
    tick();
    exp_regs[2] = 64'h7;
    check_resp("wr112", 1'b0, 64'h0);
    drive(1'b1, 1'b0, 16'h0112, 64'h0, 8'h00, 1'b1);
    tick();
    zero_model();
    check_resp("rd112.clr", 1'b0, 64'h0);
    check_regs("rd112.clr.regs");

    // Reset asserted while a read is pending: no ack follows
    drive(1'b1, 1'b1, 16'h0113, 64'hCAFE, 8'hFF, 1'b0);
    tick();
    exp_regs[3] = 64'hCAFE;
    check_resp("wr113.pre", 1'b0, 64'h0);
    drive(1'b1, 1'b0, 16'h0113, 64'h0, 8'h00, 1'b0);
    #2;
    reset = 1'b1;
    zero_model();
    tick();
    check_idle("rstmid");
    check("rstmid.rdata", FLAT'(rdata), FLAT'(64'h0));
    check_regs("rstmid.regs");
    drive(1'b0, 1'b0, 16'h0000, 64'h0, 8'h00, 1'b0);
    reset = 1'b0;
    tick();
    check_idle("rstmid.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_register_file.md
Name: bus_register_file

Overview:
- Parametrised memory-mapped register file slave for the mini-processor bus.
- Next generation of the fixed 10×64-bit register file. It has parametrised depth, width and base address, plus a registered request/acknowledge bus interface.
- New features:
  - byte-lane write strobes
  - out-of-range and read-only error responses
  - synchronous bulk clear
  - flat register observation port for the processor core (e.g. INST_REG at index 0)

Parameters:
- DEPTH, 10: number of registers, 1..64.
- WIDTH, 64: register width in bits; a multiple of 8.
- ADDR_W, 16: bus address width.
- BASE_ADDR, 16'h0110: bus address of register 0. Register i is at BASE_ADDR+i.
- RO_MASK, 0: DEPTH-bit mask. Bit i=1 makes register i read-only from the bus.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  access request; each cycle with req=1 is one access.
- wr  in  1  1=write, 0=read; qualified by req.
- addr  in  ADDR_W  bus address.
- wdata  in  WIDTH  write data.
- wstrb  in  WIDTH/8  byte-lane write enables; bit k covers wdata[8k+7:8k].
- clear  in  1  synchronous clear of all registers.
- ack  out  1  one-cycle acknowledge for the access issued in the previous cycle.
- err  out  1  error flag; valid only while ack=1.
- rdata  out  WIDTH  read data; valid only while ack=1 for a read.
- reg_q  out  DEPTH*WIDTH  flat live contents; register i occupies [i*WIDTH +: WIDTH].

Behaviour:
- Reset (asynchronous, active-high):
  - Takes effect immediately, regardless of clk.
  - All registers go to 0; ack=0, err=0, rdata=0.
  - An access in flight when reset asserts is dropped: no ack follows.
- Decode:
  - hit = (addr >= BASE_ADDR) && (addr < BASE_ADDR+DEPTH).
  - Index idx = addr-BASE_ADDR.
  - Compare at ADDR_W+1 bits so BASE_ADDR+DEPTH cannot wrap.
- Pipeline: fixed latency of 1.
  - An access sampled at edge N produces ack=1 during cycle N+1.
  - ack=0 in any cycle following a cycle with req=0.
  - Back-to-back accesses on consecutive cycles give consecutive ack cycles. There is no stall and no backpressure.
- Write (req=1, wr=1):
  - If hit and RO_MASK[idx]=0: at edge N, byte k of register idx takes wdata byte k for every wstrb[k]=1. Other bytes hold. Then err=0, rdata=0.
  - If wstrb=0: no change, err=0.
  - If miss or RO_MASK[idx]=1: no register changes; err=1 with the ack.
- Read (req=1, wr=0):
  - If hit: rdata = register idx value after edge N, i.e. including any clear or write applied at edge N. err=0.
  - If miss: rdata=0, err=1.
- Read-after-write:
  - Write at cycle N, read of the same register at cycle N+1: the read returns the new value.
  - Single bus port, so there is no same-cycle read/write conflict.
- clear:
  - At any edge with clear=1, all registers go to 0, including read-only ones.
  - clear has priority over a simultaneous bus write; that write is lost but is still acked with err=0 if it was legal.
  - A simultaneous read is acked with rdata=0.
- reg_q: combinational from the register outputs. Updates the cycle after a write or clear edge.
- Read-only registers read normally and are changed only by reset or clear. Their write error is the hook for later hardware-loaded registers.
- No X ever appears on outputs. Out-of-range accesses return defined zero data.

Decomposition:
- Shared package bus_rf_pkg:
  - constants RF_BASE_ADDR=16'h0110, RF_DEPTH=10, RF_WIDTH=64, BUS_ADDR_W=16
  - function byte_mask(wstrb) expanding strobes to a WIDTH-bit mask
- Sub-module rf_word:
  - one WIDTH-bit register with async active-high reset, sync clear, and byte-masked write enable
  - instantiated DEPTH times by a generate loop
- Top level holds the decode, error logic, response pipeline register and read mux.

Test Plan:
- Reset mid-operation: assert reset in the cycle after a read request -> no ack follows, rdata=0, all reg_q=0.
- Full write, then read, defaults: write 64'hDEAD_BEEF_0123_4567 to 16'h0113; read 16'h0113 next cycle -> ack with err=0 in each of two consecutive cycles, rdata=64'hDEAD_BEEF_0123_4567, reg_q[3*64 +: 64] matches.
- Byte strobes: register 0x0115 holds 64'h1111_1111_1111_1111; write wdata=64'hFFFF_FFFF_FFFF_FFFF with wstrb=8'b0000_0101 -> read returns 64'h1111_1111_11FF_11FF.
- Out-of-range: read 16'h011A, then read 16'h010F, then write 16'h011A -> each acked with err=1, rdata=0, no register changes.
- Read-only register: RO_MASK=10'b1 (register 0 read-only); write 64'h5 to 16'h0110 -> ack with err=1, register 0 stays 0.
- Clear priority: with register 0x0111 holding 64'hA, write 64'hB to 16'h0111 in the same cycle as clear=1 -> ack with err=0, all registers 0; a following read of 16'h0111 returns 64'h0.
